imem_fetch_buffer: RTL and testbench

//  Byte-addressed instruction memory feeding the SEQ fetch stage. A loader port writes

---
 rtl/imem_fetch_buffer.sv | 139 +++++++++++++
 tb/tb_imem_fetch_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_buffer.sv
// imem_fetch_buffer: byte-addressed instruction memory for the SEQ fetch stage.
// A loader fills the memory after reset; in RUN a fetch returns mem[PC..PC+9] one
// cycle later. Out-of-range fetches lock the block in ERR until reset.
// Optional feature: define IMEM_PARITY_EN for a per-byte even-parity bit.
module imem_fetch_buffer #(
    parameter int DEPTH = 1034,
    parameter int LD_AW = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [LD_AW-1:0] ld_addr,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    input  logic             ld_par_inv,
    output logic             ld_err,
    input  logic             fetch_req,
    input  logic [63:0]      PC,
    output logic [0:79]      instruct,
    output logic             instruct_valid,
    output logic             mem_err,
    output logic             par_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        RUN  = 2'b01,
        ERR  = 2'b10
    } state_t;

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = 9;
`else
    localparam int MEM_W = 8;
`endif

    localparam logic [LD_AW:0] DEPTH_W   = (LD_AW + 1)'(DEPTH);
    localparam logic [64:0]    LAST_ADDR = 65'(DEPTH - 1);

    // Even parity bit for one stored byte.
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    // Fetch window fits when PC+9 does not pass the last byte; 65-bit sum so no wrap.
    function automatic logic window_fits(input logic [63:0] pc);
        return ({1'b0, pc} + 65'd9) <= LAST_ADDR;
    endfunction

    logic [MEM_W-1:0] mem [DEPTH];

    state_t           state_q;
    state_t           state_nxt;
    logic             ld_accept;
    logic             addr_ok_p0;
    logic             fetch_go_p0;
    logic             window_ok_p0;
    logic [LD_AW-1:0] pc_lo;
    logic [LD_AW-1:0] idx;
    logic [0:79]      rd_word_p0;
    logic             rd_bad_p0;
    logic [MEM_W-1:0] wr_entry;

    assign ld_ready     = (state_q == LOAD);
    assign state        = state_q;
    assign ld_accept    = ld_valid & ld_ready;
    assign addr_ok_p0   = ({1'b0, ld_addr} < DEPTH_W);
    assign fetch_go_p0  = fetch_req & (state_q == RUN);
    assign window_ok_p0 = window_fits(PC);
    assign pc_lo        = PC[LD_AW-1:0];

`ifdef IMEM_PARITY_EN
    assign wr_entry = {even_par(ld_data) ^ ld_par_inv, ld_data};
`else
    assign wr_entry = ld_data;
    logic unused_par_inv;
    assign unused_par_inv = ld_par_inv;
`endif

    // Byte storage: written only by accepted in-range loader beats, never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && ld_accept && addr_ok_p0) begin
            mem[ld_addr] <= wr_entry;
        end
    end

    // Assemble the 10-byte window at PC; byte k lands in instruct[8k:8k+7].
    always_comb begin
        rd_word_p0 = '0;
        rd_bad_p0  = 1'b0;
        idx        = '0;
        for (int k = 0; k < 10; k++) begin
            idx = pc_lo + LD_AW'(k);
            rd_word_p0[8*k +: 8] = mem[idx][7:0];
`ifdef IMEM_PARITY_EN
            rd_bad_p0 = rd_bad_p0 | (^mem[idx]);
`endif
        end
    end

    // Next-state logic: LOAD ends on an accepted ld_last beat; any bad fetch is terminal.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            LOAD:    if (ld_accept && ld_last) state_nxt = RUN;
            RUN:     if (fetch_go_p0 && (!window_ok_p0 || rd_bad_p0)) state_nxt = ERR;
            ERR:     state_nxt = ERR;
            default: state_nxt = LOAD;
        endcase
    end

    // Stage p0 -> p1: state, fetch response and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            instruct       <= '0;
            instruct_valid <= 1'b0;
            ld_err         <= 1'b0;
            mem_err        <= 1'b0;
            par_err        <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            ld_err         <= ld_accept & ~addr_ok_p0;
            instruct_valid <= fetch_go_p0 & window_ok_p0;
            if (fetch_go_p0 && window_ok_p0) begin
                instruct <= rd_word_p0;
            end
            mem_err        <= mem_err | (fetch_go_p0 & ~window_ok_p0);
`ifdef IMEM_PARITY_EN
            par_err        <= par_err | (fetch_go_p0 & window_ok_p0 & rd_bad_p0);
`else
            par_err        <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Testbench for imem_fetch_buffer: directed scenarios plus randomized load/fetch
// traffic, all checked every cycle against a byte-array reference model.
module tb_imem_fetch_buffer;

    localparam int DEPTH = 1034;
    localparam int LD_AW = 11;
`ifdef IMEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             ld_valid;
    logic             ld_ready;
    logic [LD_AW-1:0] ld_addr;
    logic [7:0]       ld_data;
    logic             ld_last;
    logic             ld_par_inv;
    logic             ld_err;
    logic             fetch_req;
    logic [63:0]      PC;
    logic [0:79]      instruct;
    logic             instruct_valid;
    logic             mem_err;
    logic             par_err;
    logic [1:0]       state;

    imem_fetch_buffer #(.DEPTH(DEPTH), .LD_AW(LD_AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_par_inv     (ld_par_inv),
        .ld_err         (ld_err),
        .fetch_req      (fetch_req),
        .PC             (PC),
        .instruct       (instruct),
        .instruct_valid (instruct_valid),
        .mem_err        (mem_err),
        .par_err        (par_err),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain byte array plus a per-byte "parity was inverted" flag.
    logic [7:0]  m_mem [DEPTH];
    bit          m_inv [DEPTH];
    int          m_mode;        // 0 loading, 1 running, 2 locked in error
    logic [79:0] e_instr;
    bit          e_vld, e_ld_err, e_mem_err, e_par_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [79:0] w;
        bit          bad;
        if (!rst_n) begin
            m_mode    = 0;
            e_instr   = '0;
            e_vld     = 0;
            e_ld_err  = 0;
            e_mem_err = 0;
            e_par_err = 0;
            return;
        end
        e_vld    = 0;
        e_ld_err = 0;
        case (m_mode)
            0: if (ld_valid) begin
                if (int'(ld_addr) < DEPTH) begin
                    m_mem[int'(ld_addr)] = ld_data;
                    m_inv[int'(ld_addr)] = ld_par_inv;
                end else begin
                    e_ld_err = 1;
                end
                if (ld_last) m_mode = 1;
            end
            1: if (fetch_req) begin
                if (PC <= 64'(DEPTH - 10)) begin
                    w   = '0;
                    bad = 0;
                    for (int k = 0; k < 10; k++) begin
                        w   = {w[71:0], m_mem[int'(PC) + k]};
                        bad = bad | m_inv[int'(PC) + k];
                    end
                    e_instr = w;
                    e_vld   = 1;
                    if (PAR_EN && bad) begin
                        e_par_err = 1;
                        m_mode    = 2;
                    end
                end else begin
                    e_mem_err = 1;
                    m_mode    = 2;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("state",    80'(state),          80'(m_mode));
        chk("ld_ready", 80'(ld_ready),       80'(m_mode == 0));
        chk("instruct", instruct,            e_instr);
        chk("valid",    80'(instruct_valid), 80'(e_vld));
        chk("ld_err",   80'(ld_err),         80'(e_ld_err));
        chk("mem_err",  80'(mem_err),        80'(e_mem_err));
        chk("par_err",  80'(par_err),        80'(e_par_err));
    endtask

    // Inputs change on negedge; DUT and model both consume them at posedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ld_valid   = 0;
        ld_addr    = '0;
        ld_data    = '0;
        ld_last    = 0;
        ld_par_inv = 0;
        fetch_req  = 0;
        PC         = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic load_beat(input int addr, input logic [7:0] data, input bit last, input bit inv);
        ld_valid   = 1;
        ld_addr    = LD_AW'(addr);
        ld_data    = data;
        ld_last    = last;
        ld_par_inv = inv;
        tick();
        clear_inputs();
    endtask

    task automatic fetch(input logic [63:0] pc);
        fetch_req = 1;
        PC        = pc;
        tick();
        clear_inputs();
    endtask

    logic [7:0] prog [10];

    initial begin
        prog = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        clear_inputs();
        rst_n = 0;

        // Reset state
        tick();
        chk("rst_ready", 80'(ld_ready), 80'(1));
        chk("rst_state", 80'(state), 80'(0));
        rst_n = 1;

        // Give every byte a known value
        for (int a = 0; a < DEPTH; a++) load_beat(a, 8'($urandom), a == DEPTH - 1, 0);

        // Scenario 2: program at 4..13, fetch PC=4
        do_reset();
        for (int i = 0; i < 10; i++) load_beat(4 + i, prog[i], i == 9, 0);
        fetch(64'd4);
        chk("s2_word", instruct, 80'h30F2_0000_0000_0000_0002);
        chk("s2_valid", 80'(instruct_valid), 80'(1));
        tick();
        chk("s2_pulse", 80'(instruct_valid), 80'(0));
        chk("s2_hold", instruct, 80'h30F2_0000_0000_0000_0002);

        // Back-to-back fetches, then boundary cases
        for (int i = 0; i < 8; i++) fetch(64'($urandom_range(DEPTH - 10)));
        fetch(64'd1024);
        chk("s3_last_ok", 80'(mem_err), 80'(0));
        fetch(64'd1025);
        chk("s3_err", 80'(mem_err), 80'(1));
        chk("s3_state", 80'(state), 80'(2));
        fetch(64'd4);
        chk("s3_locked", 80'(instruct_valid), 80'(0));
        load_beat(20, 8'hAA, 1, 0);

        // Scenario 4: fetches in LOAD ignored, out-of-range beat dropped
        do_reset();
        fetch_req = 1;
        PC        = 64'd4;
        tick();
        load_beat(DEPTH, 8'h55, 0, 0);
        chk("s4_ld_err", 80'(ld_err), 80'(1));
        load_beat(2047, 8'h66, 0, 0);
        fetch_req = 1;
        PC        = 64'd4;
        load_beat(13, 8'h02, 1, 0);
        chk("s4_last_nofetch", 80'(instruct_valid), 80'(0));
        fetch(64'd4);
        chk("s4_word", instruct, 80'h30F2_0000_0000_0000_0002);
        fetch(64'hFFFF_FFFF_FFFF_FFFB);
        chk("s4_wrap_err", 80'(mem_err), 80'(1));

        // Scenario 5: reset mid-load, memory survives
        do_reset();
        for (int i = 0; i < 5; i++) load_beat(4 + i, prog[i], 0, 0);
        do_reset();
        for (int i = 5; i < 10; i++) load_beat(4 + i, prog[i], i == 9, 0);
        fetch(64'd4);
        chk("s5_word", instruct, 80'h30F2_0000_0000_0000_0002);

        // Scenario 6: inverted parity on byte 5
        do_reset();
        load_beat(5, prog[1], 1, 1);
        fetch(64'd4);
        chk("s6_par", 80'(par_err), 80'(PAR_EN));
        chk("s6_word", instruct, 80'h30F2_0000_0000_0000_0002);
        do_reset();
        load_beat(5, prog[1], 1, 0);

        // Randomized traffic
        for (int r = 0; r < 30; r++) begin
            do_reset();
            for (int b = 0; b < 40 && m_mode == 0; b++) begin
                ld_valid   = ($urandom_range(3) != 0);
                ld_addr    = ($urandom_range(9) == 0) ? LD_AW'($urandom_range(2047, DEPTH))
                                                      : LD_AW'($urandom_range(DEPTH - 1));
                ld_data    = 8'($urandom);
                ld_par_inv = ($urandom_range(15) == 0);
                ld_last    = (b == 39) || ($urandom_range(19) == 0);
                fetch_req  = $urandom_range(1);
                PC         = 64'($urandom_range(DEPTH - 10));
                tick();
            end
            clear_inputs();
            for (int c = 0; c < 40; c++) begin
                fetch_req = ($urandom_range(9) < 7);
                case ($urandom_range(19))
                    0:       PC = {32'($urandom), 32'($urandom)};
                    1:       PC = 64'($urandom_range(DEPTH + 6, DEPTH - 9));
                    default: PC = 64'($urandom_range(DEPTH - 10));
                endcase
                ld_valid = $urandom_range(1);
                ld_addr  = LD_AW'($urandom_range(DEPTH - 1));
                ld_data  = 8'($urandom);
                ld_last  = $urandom_range(1);
                rst_n    = ($urandom_range(49) != 0);
                tick();
                rst_n = 1;
            end
            clear_inputs();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
